// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port, with a busy-bit
// scoreboard for RAW/WAW issue stalls. Define RFARB_FIXED_PRIO_EN for fixed port-0 priority.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_req0_valid,
   input  logic [AW-1:0]   i_req0_rd,
   input  logic [XLEN-1:0] i_req0_data,
   output logic            o_req0_ready,
   input  logic            i_req1_valid,
   input  logic [AW-1:0]   i_req1_rd,
   input  logic [XLEN-1:0] i_req1_data,
   output logic            o_req1_ready,
   input  logic            i_iss_valid,
   input  logic [AW-1:0]   i_iss_rs1,
   input  logic [AW-1:0]   i_iss_rs2,
   input  logic [AW-1:0]   i_iss_rd,
   input  logic            i_iss_wen,
   output logic            o_iss_stall,
   output logic            o_rf_we,
   output logic [AW-1:0]   o_rf_rd,
   output logic [XLEN-1:0] o_rf_wdata,
   output logic [NREG-1:0] o_busy_vec
);

   logic            r_rf_we;
   logic [AW-1:0]   r_rf_rd;
   logic [XLEN-1:0] r_rf_wdata;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_grant0;
   logic            w_grant1;
   logic            w_hs;
   logic [AW-1:0]   w_sel_rd;
   logic [XLEN-1:0] w_sel_data;
   logic            w_iss_fire;

`ifdef RFARB_FIXED_PRIO_EN
   assign w_grant0 = i_req0_valid;
`else
   // r_last_grant=1 means port 1 was served last, so port 0 wins a conflict
   logic r_last_grant;

   assign w_grant0 = i_req0_valid & (~i_req1_valid | r_last_grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_grant <= 1'b1;
      else if (w_hs)
         r_last_grant <= w_grant1;
   end
`endif

   assign w_grant1   = i_req1_valid & ~w_grant0;
   assign w_hs       = w_grant0 | w_grant1;
   assign w_sel_rd   = w_grant0 ? i_req0_rd   : i_req1_rd;
   assign w_sel_data = w_grant0 ? i_req0_data : i_req1_data;

   assign o_req0_ready = w_grant0;
   assign o_req1_ready = w_grant1;

   // x0 writes complete the handshake but never reach the register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= w_hs & (w_sel_rd != '0);
         if (w_hs && w_sel_rd != '0) begin
            r_rf_rd    <= w_sel_rd;
            r_rf_wdata <= w_sel_data;
         end
      end
   end

   assign o_iss_stall = i_iss_valid &
                        (((i_iss_rs1 != '0) & r_busy[i_iss_rs1]) |
                         ((i_iss_rs2 != '0) & r_busy[i_iss_rs2]) |
                         (i_iss_wen & (i_iss_rd != '0) & r_busy[i_iss_rd]));

   assign w_iss_fire = i_iss_valid & ~o_iss_stall & i_iss_wen & (i_iss_rd != '0);

   // Clear first so a same-edge set on the same register wins
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_rf_we)
         w_busy_nxt[r_rf_rd] = 1'b0;
      if (w_iss_fire)
         w_busy_nxt[i_iss_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= w_busy_nxt;
   end

   assign o_rf_we    = r_rf_we;
   assign o_rf_rd    = r_rf_rd;
   assign o_rf_wdata = r_rf_wdata;
   assign o_busy_vec = r_busy;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (ALU/execute) and port 1 (multi-cycle LSU/MUL-DIV).
- Keeps a busy-bit scoreboard of in-flight destination registers and stalls issue on RAW/WAW hazards.
- Sits between the execute/memory units and the register file; drives the register file's RegWrite/rd/WriteData through a registered commit stage.

Parameters:
- XLEN, 32, data width of the write port.
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; must equal clog2(NREG).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 write request.
- req0_rd  in  AW  port 0 destination register.
- req0_data  in  XLEN  port 0 write data.
- req0_ready  out  1  port 0 granted this cycle.
- req1_valid  in  1  port 1 write request.
- req1_rd  in  AW  port 1 destination register.
- req1_data  in  XLEN  port 1 write data.
- req1_ready  out  1  port 1 granted this cycle.
- iss_valid  in  1  decode presents an instruction.
- iss_rs1  in  AW  source register 1 of issuing instruction.
- iss_rs2  in  AW  source register 2 of issuing instruction.
- iss_rd  in  AW  destination register of issuing instruction.
- iss_wen  in  1  issuing instruction writes iss_rd.
- iss_stall  out  1  hazard; instruction must not issue.
- rf_we  out  1  register file write enable (to RegWrite).
- rf_rd  out  AW  register file write address.
- rf_wdata  out  XLEN  register file write data.
- busy_vec  out  NREG  current scoreboard, bit 0 always 0.

Behaviour:
- Reset (asynchronous, rst_n low): rf_we=0, rf_rd=0, rf_wdata=0, busy_vec=0, last_grant=1 (so port 0 wins first conflict). req*_ready and iss_stall reflect combinational logic on the reset state.
- Arbitration (combinational, same cycle):
  - At most one grant per cycle.
  - Only one valid port → that port is granted.
  - Both valid → round-robin: grant the port not in last_grant.
  - last_grant updates on every handshake (valid & ready).
  - req*_ready asserted only for the granted port; requesters hold valid/rd/data stable until ready.
- Commit stage (one cycle latency): on the clock edge after a handshake, rf_we=1, rf_rd=granted rd, rf_wdata=granted data. No handshake → rf_we=0; rf_rd/rf_wdata hold.
- rd==0 requests: handshake completes (ready=1), but rf_we stays 0 next cycle.
- Scoreboard:
  - Issue fire = iss_valid & !iss_stall & iss_wen & iss_rd!=0; sets busy[iss_rd] at the edge.
  - Commit clears busy[rf_rd] at the edge where rf_we=1 (same edge the register file writes), so a reader unblocked next cycle sees new data.
  - Same register set and cleared on one edge → set wins.
  - Commit to a non-busy register is legal; the bit stays 0.
- Stall: iss_stall = iss_valid & ((rs1!=0 & busy[rs1]) | (rs2!=0 & busy[rs2]) | (iss_wen & rd!=0 & busy[rd])). iss_valid=0 → iss_stall=0.
- Reset mid-operation: pending commit and all busy bits discarded; no write issued after rst_n deasserts until a new handshake.

Optional Feature:
- Macro: RFARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins a conflict; last_grant register removed.
- Undefined: round-robin as above.

Test Plan:
- Reset: hold rst_n=0 mid-stream with busy bits set → all outputs 0, busy_vec=0 immediately, no rf_we after release.
- Single write: req0 rd=5 data=0xDEADBEEF → req0_ready same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Conflict: req0 rd=3 and req1 rd=4 held valid 3 cycles → grants alternate 0,1,0; commits rd 3,4,3 (fixed-priority build: 3,3,3 with req1 starved).
- RAW stall: issue rd=7 with iss_wen=1, then iss_rs1=7 → stall=1 until the cycle after rf_we commits rd=7, then stall=0.
- x0 rules: req1 rd=0 → ready=1, no rf_we. Issue rd=0, iss_wen=1 → busy_vec unchanged. iss_rs2=0 never stalls.
- Set/clear collision: rd=9 committing while a new issue to rd=9 fires → busy[9] remains 1.
